// File: rtl/accum_fsm_pkg.sv
// +----------------------------------------------------------------------+
// | accum_fsm_pkg : mode encoding and mode sequencing helper             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package accum_fsm_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'd0,
    MODE_ACCUM = 2'd1,
    MODE_LOAD  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_t;

  // Wraps to CLEAR after the last mode of the cycle; any out-of-range mode also returns to CLEAR.
  function automatic mode_t next_mode(input mode_t m, input int n_modes);
    if (int'(m) + 1 >= n_modes) begin
      return MODE_CLEAR;
    end
    return mode_t'(m + 2'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/accum_sat_add.sv
// +----------------------------------------------------------------------+
// | accum_sat_add : ACC_W adder with carry out and optional clamp        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module accum_sat_add #(
  parameter int ACC_W    = 26,
  parameter int SATURATE = 0
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_full[ACC_W];

  if (SATURATE != 0) begin : g_sat
    assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
  end else begin : g_wrap
    assign o_sum = w_full[ACC_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/accum_fsm.sv
// +----------------------------------------------------------------------+
// | accum_fsm : mode-sequenced clear/accumulate/load/hold accumulator    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module accum_fsm
  import accum_fsm_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 26,
  parameter int OUT_LSB  = 0,
  parameter int SATURATE = 0,
  parameter int N_MODES  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [1:0]        mode,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              overflow
);

  if (ACC_W < OUT_LSB + DATA_W) begin : g_chk_width
    $fatal(1, "accum_fsm: ACC_W must be >= OUT_LSB + DATA_W");
  end
  if (N_MODES != 3 && N_MODES != 4) begin : g_chk_modes
    $fatal(1, "accum_fsm: N_MODES must be 3 or 4");
  end

  mode_t            mode_q, mode_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;

  logic [ACC_W-1:0] w_sample;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  assign w_sample = ACC_W'(in_data);

  accum_sat_add #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_add (
    .i_a     (acc_q),
    .i_b     (w_sample),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_comb begin
    mode_d      = mode_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;

    // An out-of-range mode (HOLD when only three modes exist) recovers without needing advance.
    if (int'(mode_q) >= N_MODES) begin
      mode_d = MODE_CLEAR;
    end else if (advance) begin
      mode_d = next_mode(mode_q, N_MODES);
    end

    // The datapath acts under the mode in effect before this edge.
    case (mode_q)
      MODE_CLEAR: begin
        acc_d      = '0;
        overflow_d = 1'b0;
      end
      MODE_ACCUM: begin
        if (in_valid) begin
          acc_d       = w_sum;
          overflow_d  = overflow_q | w_carry;
          out_valid_d = 1'b1;
        end
      end
      MODE_LOAD: begin
        if (in_valid) begin
          acc_d       = w_sample;
          out_valid_d = 1'b1;
        end
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_CLEAR;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign mode      = mode_q;
  assign out_data  = acc_q[OUT_LSB +: DATA_W];
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_accum_fsm.sv
// +----------------------------------------------------------------------+
// | tb_accum_fsm : scoreboard bench over four parameterisations          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_accum_fsm;
  import accum_fsm_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic        vld;
    logic [1:0]  mode;
    logic        ovf;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        advance = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;

  always #5 clk = ~clk;

  // base: defaults; wrap: 17-bit wrapping; sat: 17-bit clamping with HOLD; lsb: window at bit 4 with HOLD
  logic [1:0]  base_mode, wrap_mode, sat_mode, lsb_mode;
  logic [15:0] base_data, wrap_data, sat_data, lsb_data;
  logic        base_vld, wrap_vld, sat_vld, lsb_vld;
  logic        base_ovf, wrap_ovf, sat_ovf, lsb_ovf;
  obs_t        obs_base, obs_wrap, obs_sat, obs_lsb;

  assign obs_base = {base_data, base_vld, base_mode, base_ovf};
  assign obs_wrap = {wrap_data, wrap_vld, wrap_mode, wrap_ovf};
  assign obs_sat  = {sat_data,  sat_vld,  sat_mode,  sat_ovf};
  assign obs_lsb  = {lsb_data,  lsb_vld,  lsb_mode,  lsb_ovf};

  accum_fsm u_base (
    .clk(clk), .rst(rst), .advance(advance), .in_valid(in_valid), .in_data(in_data),
    .mode(base_mode), .out_data(base_data), .out_valid(base_vld), .overflow(base_ovf)
  );

  accum_fsm #(.DATA_W(16), .ACC_W(17), .OUT_LSB(0), .SATURATE(0), .N_MODES(3)) u_wrap (
    .clk(clk), .rst(rst), .advance(advance), .in_valid(in_valid), .in_data(in_data),
    .mode(wrap_mode), .out_data(wrap_data), .out_valid(wrap_vld), .overflow(wrap_ovf)
  );

  accum_fsm #(.DATA_W(16), .ACC_W(17), .OUT_LSB(0), .SATURATE(1), .N_MODES(4)) u_sat (
    .clk(clk), .rst(rst), .advance(advance), .in_valid(in_valid), .in_data(in_data),
    .mode(sat_mode), .out_data(sat_data), .out_valid(sat_vld), .overflow(sat_ovf)
  );

  accum_fsm #(.DATA_W(16), .ACC_W(26), .OUT_LSB(4), .SATURATE(0), .N_MODES(4)) u_lsb (
    .clk(clk), .rst(rst), .advance(advance), .in_valid(in_valid), .in_data(in_data),
    .mode(lsb_mode), .out_data(lsb_data), .out_valid(lsb_vld), .overflow(lsb_ovf)
  );

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic obs_t mk(input logic [15:0] d, input logic v, input logic [1:0] m, input logic o);
    obs_t r;
    r.data = d;
    r.vld  = v;
    r.mode = m;
    r.ovf  = o;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic adv, input logic vld, input logic [15:0] d);
    advance  = adv;
    in_valid = vld;
    in_data  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t exp;
    do_reset();
    exp = mk(16'h0, 1'b0, MODE_CLEAR, 1'b0);
    n_checks++;
    if (obs_base !== exp) begin n_errors++; $display("FAIL reset_base: got %h expected %h", obs_base, exp); end
    n_checks++;
    if (obs_wrap !== exp) begin n_errors++; $display("FAIL reset_wrap: got %h expected %h", obs_wrap, exp); end
    n_checks++;
    if (obs_sat !== exp) begin n_errors++; $display("FAIL reset_sat: got %h expected %h", obs_sat, exp); end
    n_checks++;
    if (obs_lsb !== exp) begin n_errors++; $display("FAIL reset_lsb: got %h expected %h", obs_lsb, exp); end
  endtask

  task automatic test_accumulate();
    logic [15:0] smp [3] = '{16'd5, 16'd7, 16'd9};
    logic [15:0] run;
    obs_t        exp;
    do_reset();
    drive(1'b1, 1'b0, 16'h0);
    tick();
    run = '0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, smp[i]);
      run = run + smp[i];
      sb_q.push_back(mk(run, 1'b1, MODE_ACCUM, 1'b0));
      tick();
      exp = sb_q.pop_front();
      n_checks++;
      if (obs_base !== exp) begin n_errors++; $display("FAIL accum_s%0d: got %h expected %h", i, obs_base, exp); end
    end
    drive(1'b0, 1'b0, 16'h0);
    sb_q.push_back(mk(16'd21, 1'b0, MODE_ACCUM, 1'b0));
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_base !== exp) begin n_errors++; $display("FAIL accum_idle: got %h expected %h", obs_base, exp); end
  endtask

  // Wrap vs clamp at 17 bits, then advance-with-sample into LOAD and a plain LOAD with overflow sticky.
  task automatic test_overflow();
    logic [15:0] smp [7] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 16'h0005, 16'h0003, 16'h0004};
    logic        adv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    obs_t        w_exp [7];
    obs_t        s_exp [7];
    obs_t        exp;
    w_exp[0] = mk(16'hFFFF, 1'b1, MODE_ACCUM, 1'b0);  s_exp[0] = mk(16'hFFFF, 1'b1, MODE_ACCUM, 1'b0);
    w_exp[1] = mk(16'hFFFE, 1'b1, MODE_ACCUM, 1'b0);  s_exp[1] = mk(16'hFFFE, 1'b1, MODE_ACCUM, 1'b0);
    w_exp[2] = mk(16'hFFFF, 1'b1, MODE_ACCUM, 1'b0);  s_exp[2] = mk(16'hFFFF, 1'b1, MODE_ACCUM, 1'b0);
    w_exp[3] = mk(16'h0000, 1'b1, MODE_ACCUM, 1'b1);  s_exp[3] = mk(16'hFFFF, 1'b1, MODE_ACCUM, 1'b1);
    w_exp[4] = mk(16'h0005, 1'b1, MODE_ACCUM, 1'b1);  s_exp[4] = mk(16'hFFFF, 1'b1, MODE_ACCUM, 1'b1);
    w_exp[5] = mk(16'h0008, 1'b1, MODE_LOAD,  1'b1);  s_exp[5] = mk(16'hFFFF, 1'b1, MODE_LOAD,  1'b1);
    w_exp[6] = mk(16'h0004, 1'b1, MODE_LOAD,  1'b1);  s_exp[6] = mk(16'h0004, 1'b1, MODE_LOAD,  1'b1);
    do_reset();
    drive(1'b1, 1'b0, 16'h0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(adv[i], 1'b1, smp[i]);
      sb_q.push_back(w_exp[i]);
      sb_q.push_back(s_exp[i]);
      tick();
      exp = sb_q.pop_front();
      n_checks++;
      if (obs_wrap !== exp) begin n_errors++; $display("FAIL ovf_wrap_s%0d: got %h expected %h", i, obs_wrap, exp); end
      exp = sb_q.pop_front();
      n_checks++;
      if (obs_sat !== exp) begin n_errors++; $display("FAIL ovf_sat_s%0d: got %h expected %h", i, obs_sat, exp); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp;
    do_reset();
    drive(1'b1, 1'b0, 16'h0);
    tick();
    drive(1'b0, 1'b1, 16'd10);
    tick();
    drive(1'b1, 1'b1, 16'd3);
    sb_q.push_back(mk(16'd13, 1'b1, MODE_LOAD, 1'b0));
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_base !== exp) begin n_errors++; $display("FAIL b2b_adv_sample: got %h expected %h", obs_base, exp); end
    drive(1'b0, 1'b1, 16'd4);
    sb_q.push_back(mk(16'd4, 1'b1, MODE_LOAD, 1'b0));
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_base !== exp) begin n_errors++; $display("FAIL b2b_load: got %h expected %h", obs_base, exp); end
  endtask

  task automatic test_mode_cycle();
    obs_t exp;
    do_reset();
    drive(1'b1, 1'b0, 16'h0);
    tick();
    drive(1'b1, 1'b1, 16'h0055);
    sb_q.push_back(mk(16'h0055, 1'b1, MODE_LOAD, 1'b0));
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_base !== exp) begin n_errors++; $display("FAIL cyc_to_load: got %h expected %h", obs_base, exp); end
    drive(1'b1, 1'b0, 16'h0);
    sb_q.push_back(mk(16'h0055, 1'b0, MODE_CLEAR, 1'b0));
    sb_q.push_back(mk(16'h0055, 1'b0, MODE_HOLD, 1'b0));
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_base !== exp) begin n_errors++; $display("FAIL cyc3_to_clear: got %h expected %h", obs_base, exp); end
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_sat !== exp) begin n_errors++; $display("FAIL cyc4_to_hold: got %h expected %h", obs_sat, exp); end
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 16'(k));
      if (k == 1) sb_q.push_back(mk(16'h0000, 1'b0, MODE_CLEAR, 1'b0));
      sb_q.push_back(mk(16'h0055, 1'b0, MODE_HOLD, 1'b0));
      tick();
      if (k == 1) begin
        exp = sb_q.pop_front();
        n_checks++;
        if (obs_base !== exp) begin n_errors++; $display("FAIL cyc3_zero: got %h expected %h", obs_base, exp); end
      end
      exp = sb_q.pop_front();
      n_checks++;
      if (obs_sat !== exp) begin n_errors++; $display("FAIL hold_s%0d: got %h expected %h", k, obs_sat, exp); end
    end
    drive(1'b1, 1'b1, 16'd9);
    sb_q.push_back(mk(16'h0055, 1'b0, MODE_CLEAR, 1'b0));
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_sat !== exp) begin n_errors++; $display("FAIL hold_exit: got %h expected %h", obs_sat, exp); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] smp [5] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 16'h03FF};
    obs_t        exp;
    do_reset();
    drive(1'b1, 1'b0, 16'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, smp[i]);
      tick();
    end
    sb_q.push_back(mk(16'h03FF, 1'b1, MODE_ACCUM, 1'b1));
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_wrap !== exp) begin n_errors++; $display("FAIL rstmid_setup: got %h expected %h", obs_wrap, exp); end
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0077);
    for (int j = 0; j < 4; j++) sb_q.push_back(mk(16'h0, 1'b0, MODE_CLEAR, 1'b0));
    tick();
    rst = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_wrap !== exp) begin n_errors++; $display("FAIL rstmid_wrap: got %h expected %h", obs_wrap, exp); end
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_base !== exp) begin n_errors++; $display("FAIL rstmid_base: got %h expected %h", obs_base, exp); end
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_sat !== exp) begin n_errors++; $display("FAIL rstmid_sat: got %h expected %h", obs_sat, exp); end
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_lsb !== exp) begin n_errors++; $display("FAIL rstmid_lsb: got %h expected %h", obs_lsb, exp); end
  endtask

  task automatic test_out_window();
    obs_t exp;
    do_reset();
    drive(1'b1, 1'b0, 16'h0);
    tick();
    tick();
    drive(1'b0, 1'b1, 16'h1230);
    sb_q.push_back(mk(16'h0123, 1'b1, MODE_LOAD, 1'b0));
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_lsb !== exp) begin n_errors++; $display("FAIL win_load: got %h expected %h", obs_lsb, exp); end
    drive(1'b1, 1'b0, 16'h0);
    tick();
    sb_q.push_back(mk(16'h0123, 1'b0, MODE_CLEAR, 1'b0));
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_lsb !== exp) begin n_errors++; $display("FAIL win_to_clear: got %h expected %h", obs_lsb, exp); end
    drive(1'b0, 1'b0, 16'h0);
    sb_q.push_back(mk(16'h0000, 1'b0, MODE_CLEAR, 1'b0));
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (obs_lsb !== exp) begin n_errors++; $display("FAIL win_cleared: got %h expected %h", obs_lsb, exp); end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_overflow();
    test_back_to_back();
    test_mode_cycle();
    test_reset_mid();
    test_out_window();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
